// File: rtl/otp_pkg.sv
// Shared types and default sizes for the one-time-pad stream decryptor.
package otp_pkg;

  localparam int OTP_W_DEFAULT         = 8;
  localparam int OTP_KEY_DEPTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_EXHAUSTED
  } otp_state_e;

endpackage

// File: rtl/otp_pad_ram.sv
// Key pad storage: one write port, one combinational read port, single-entry clear, global clear.
module otp_pad_ram #(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_all_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          clr_en_i,
  input  logic [AW-1:0] clr_addr_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  // Global clear wins; a write and a single-entry clear never target the same cycle in practice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clr_all_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (we_i)     mem_q[waddr_i]    <= wdata_i;
      if (clr_en_i) mem_q[clr_addr_i] <= '0;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/otp_stream_decrypt.sv
// Streaming one-time-pad decryptor: load a key pad, then XOR each ciphertext word with the next pad word.
// Optional macro OTP_KEY_WRAP_EN selects repeating-key mode (no zeroize, no exhaustion).
module otp_stream_decrypt
  import otp_pkg::*;
#(
  parameter int W         = OTP_W_DEFAULT,
  parameter int KEY_DEPTH = OTP_KEY_DEPTH_DEFAULT,
  parameter int AW        = $clog2(KEY_DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         abort,
  input  logic         key_in_valid,
  input  logic [W-1:0] key_in_data,
  input  logic         key_in_last,
  output logic         key_in_ready,
  input  logic         ct_valid,
  input  logic [W-1:0] ct_data,
  output logic         ct_ready,
  output logic         pt_valid,
  output logic [W-1:0] pt_data,
  input  logic         pt_ready,
  output logic         busy,
  output logic         exhausted,
  output logic [AW:0]  words_left
);

  localparam logic [AW:0] ONE     = (AW+1)'(1);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(KEY_DEPTH);

  otp_state_e   state_q, state_d;
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]  key_len_q, key_len_d;
  logic         pt_valid_q, pt_valid_d;
  logic [W-1:0] pt_data_q, pt_data_d;

  logic          pad_we, pad_clr_en, pad_clr_all;
  logic [AW-1:0] pad_waddr;
  logic [W-1:0]  pad_rdata;
  logic          key_hs, ct_hs, last_word;

  otp_pad_ram #(.W(W), .DEPTH(KEY_DEPTH), .AW(AW)) u_pad (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_all_i  (pad_clr_all),
    .we_i       (pad_we),
    .waddr_i    (pad_waddr),
    .wdata_i    (key_in_data),
    .clr_en_i   (pad_clr_en),
    .clr_addr_i (rd_ptr_q[AW-1:0]),
    .raddr_i    (rd_ptr_q[AW-1:0]),
    .rdata_o    (pad_rdata)
  );

  // Handshakes: a word transfers on a rising edge where valid && ready; valid never waits on ready,
  // and pt_valid/pt_data hold steady until pt_ready is seen.
  assign key_in_ready = (state_q == ST_IDLE) || ((state_q == ST_LOAD) && (wr_ptr_q < DEPTH_C));
  assign ct_ready     = (state_q == ST_RUN) && (!pt_valid_q || pt_ready);
  assign key_hs       = key_in_valid && key_in_ready;
  assign ct_hs        = ct_valid && ct_ready;
  assign last_word    = (rd_ptr_q == (key_len_q - ONE));

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    key_len_d   = key_len_q;
    pt_valid_d  = pt_valid_q;
    pt_data_d   = pt_data_q;
    pad_we      = 1'b0;
    pad_waddr   = wr_ptr_q[AW-1:0];
    pad_clr_en  = 1'b0;
    pad_clr_all = 1'b0;

    if (ct_hs) begin
      pt_valid_d = 1'b1;
      pt_data_d  = ct_data ^ pad_rdata;
    end else if (pt_ready) begin
      pt_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (key_hs) begin
          pad_we    = 1'b1;
          pad_waddr = '0;
          wr_ptr_d  = ONE;
          if (key_in_last) begin
            key_len_d = ONE;
            state_d   = ST_RUN;
          end else begin
            state_d   = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (key_hs) begin
          pad_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + ONE;
          if (key_in_last || (wr_ptr_q == DEPTH_C - ONE)) begin
            key_len_d = wr_ptr_q + ONE;
            state_d   = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (ct_hs) begin
`ifdef OTP_KEY_WRAP_EN
          rd_ptr_d = last_word ? '0 : rd_ptr_q + ONE;
`else
          pad_clr_en = 1'b1;
          rd_ptr_d   = rd_ptr_q + ONE;
          if (last_word) state_d = ST_EXHAUSTED;
`endif
        end
      end
      default: ;
    endcase

    if (abort) begin
      state_d     = ST_IDLE;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      key_len_d   = '0;
      pt_valid_d  = 1'b0;
      pt_data_d   = '0;
      pad_we      = 1'b0;
      pad_clr_en  = 1'b0;
      pad_clr_all = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      key_len_q  <= '0;
      pt_valid_q <= 1'b0;
      pt_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      key_len_q  <= key_len_d;
      pt_valid_q <= pt_valid_d;
      pt_data_q  <= pt_data_d;
    end
  end

  always_comb begin
    case (state_q)
      ST_RUN, ST_EXHAUSTED: words_left = key_len_q - rd_ptr_q;
      ST_LOAD:              words_left = wr_ptr_q;
      default:              words_left = '0;
    endcase
  end

  assign pt_valid = pt_valid_q;
  assign pt_data  = pt_data_q;
  assign busy     = (state_q == ST_RUN);
`ifdef OTP_KEY_WRAP_EN
  assign exhausted = 1'b0;
`else
  assign exhausted = (state_q == ST_EXHAUSTED);
`endif

endmodule

// File: tb/tb_otp_stream_decrypt.sv
// Bench for otp_stream_decrypt (KEY_DEPTH=4): queue-based pad model, per-cycle compare, directed vectors.
module tb_otp_stream_decrypt;

  localparam int W  = 8;
  localparam int KD = 4;
  localparam int AW = 2;
`ifdef OTP_KEY_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          abort;
  logic          key_in_valid;
  logic [W-1:0]  key_in_data;
  logic          key_in_last;
  logic          key_in_ready;
  logic          ct_valid;
  logic [W-1:0]  ct_data;
  logic          ct_ready;
  logic          pt_valid;
  logic [W-1:0]  pt_data;
  logic          pt_ready;
  logic          busy;
  logic          exhausted;
  logic [AW:0]   words_left;

  otp_stream_decrypt #(.W(W), .KEY_DEPTH(KD)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .abort        (abort),
    .key_in_valid (key_in_valid),
    .key_in_data  (key_in_data),
    .key_in_last  (key_in_last),
    .key_in_ready (key_in_ready),
    .ct_valid     (ct_valid),
    .ct_data      (ct_data),
    .ct_ready     (ct_ready),
    .pt_valid     (pt_valid),
    .pt_data      (pt_data),
    .pt_ready     (pt_ready),
    .busy         (busy),
    .exhausted    (exhausted),
    .words_left   (words_left)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model ----------------
  int n_chk  = 0;
  int n_pass = 0;
  bit mon_en = 1'b0;

  logic [W-1:0] m_load[$];
  logic [W-1:0] m_pad[$];
  int           m_idx = 0;
  bit           m_running = 1'b0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  logic [W-1:0] lit_q[$];
  logic [W-1:0] ct_src_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic void model_clear();
    m_load.delete();
    m_pad.delete();
    exp_q.delete();
    m_idx     = 0;
    m_running = 1'b0;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      int  left;
      bit  pend, e_busy, e_exh;
      pend   = (exp_q.size() > 0);
      left   = m_running ? (m_pad.size() - m_idx) : 0;
      e_busy = m_running && (WRAP || left > 0);
      e_exh  = m_running && !WRAP && left == 0;
      chk("key_in_ready", {31'b0, key_in_ready}, {31'b0, !m_running});
      chk("busy", {31'b0, busy}, {31'b0, e_busy});
      chk("exhausted", {31'b0, exhausted}, {31'b0, e_exh});
      chk("ct_ready", {31'b0, ct_ready}, {31'b0, e_busy && (!pend || pt_ready)});
      chk("pt_valid", {31'b0, pt_valid}, {31'b0, pend});
      if (pend) chk("pt_data", {24'b0, pt_data}, {24'b0, exp_q[0]});
      chk("words_left", {29'b0, words_left}, m_running ? left : m_load.size());
      if (abort) begin
        model_clear();
      end else begin
        if (pt_valid && pt_ready && pend) begin
          got_q.push_back(pt_data);
          void'(exp_q.pop_front());
        end
        if (ct_valid && ct_ready && m_running && m_idx < m_pad.size()) begin
          exp_q.push_back(ct_data ^ m_pad[m_idx]);
          m_idx++;
          if (WRAP && m_idx == m_pad.size()) m_idx = 0;
        end
        if (key_in_valid && key_in_ready && !m_running) begin
          m_load.push_back(key_in_data);
          if (key_in_last || m_load.size() == KD) begin
            m_pad     = m_load;
            m_load.delete();
            m_idx     = 0;
            m_running = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load_key(input logic [W-1:0] w, input logic last);
    bit hs = 1'b0;
    key_in_valid = 1'b1;
    key_in_data  = w;
    key_in_last  = last;
    for (int i = 0; i < 20 && !hs; i++) begin
      @(negedge clk);
      hs = key_in_ready;
      @(posedge clk);
      #1;
    end
    if (!hs) chk("key_accept_timeout", 32'd0, 32'd1);
    key_in_valid = 1'b0;
    key_in_last  = 1'b0;
  endtask

  task automatic stream(input int stall);
    bit first_seen = 1'b0;
    bit done       = 1'b0;
    int stall_cnt  = 0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      if (ct_src_q.size() == 0 && exp_q.size() == 0) begin
        done = 1'b1;
      end else begin
        bit hs;
        ct_valid = (ct_src_q.size() > 0);
        ct_data  = ct_valid ? ct_src_q[0] : '0;
        pt_ready = !(first_seen && stall_cnt < stall);
        @(negedge clk);
        hs = ct_valid && ct_ready;
        @(posedge clk);
        #1;
        if (first_seen) stall_cnt++;
        if (hs) begin
          void'(ct_src_q.pop_front());
          first_seen = 1'b1;
        end
      end
    end
    if (!done) chk("stream_timeout", 32'd0, 32'd1);
    ct_valid = 1'b0;
    ct_data  = '0;
    pt_ready = 1'b1;
  endtask

  task automatic check_got(input string name);
    chk({name, "_count"}, got_q.size(), lit_q.size());
    for (int i = 0; i < lit_q.size() && i < got_q.size(); i++)
      chk(name, {24'b0, got_q[i]}, {24'b0, lit_q[i]});
    got_q.delete();
  endtask

  task automatic do_abort();
    abort = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    abort = 1'b0;
  endtask

  task automatic load_a5_pad();
    load_key(8'hA5, 1'b0);
    load_key(8'h3C, 1'b0);
    load_key(8'hFF, 1'b0);
    load_key(8'h00, 1'b1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0; abort = 1'b0; key_in_valid = 1'b0; key_in_data = '0; key_in_last = 1'b0;
    ct_valid = 1'b0; ct_data = '0; pt_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_pt_valid", {31'b0, pt_valid}, 32'd0);
    chk("rst_pt_data", {24'b0, pt_data}, 32'd0);
    chk("rst_exhausted", {31'b0, exhausted}, 32'd0);
    chk("rst_words_left", {29'b0, words_left}, 32'd0);
    chk("rst_key_ready", {31'b0, key_in_ready}, 32'd1);
    chk("rst_ct_ready", {31'b0, ct_ready}, 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Full throughput through a 4-word pad.
    load_a5_pad();
    chk("run_words_left", {29'b0, words_left}, 32'd4);
    ct_src_q = '{8'h0F, 8'h0F, 8'h0F, 8'h0F};
    stream(0);
    lit_q = '{8'hAA, 8'h33, 8'hF0, 8'h0F};
    check_got("tput_pt");
    if (!WRAP) begin
      ct_valid = 1'b1;
      ct_data  = 8'h0F;
      @(negedge clk);
      chk("fifth_ct_ready", {31'b0, ct_ready}, 32'd0);
      chk("fifth_exhausted", {31'b0, exhausted}, 32'd1);
      chk("fifth_words_left", {29'b0, words_left}, 32'd0);
      @(posedge clk); #1;
      ct_valid = 1'b0;
    end

    // Backpressure for 3 cycles after the first accept.
    do_abort();
    load_a5_pad();
    ct_src_q = '{8'h0F, 8'h0F, 8'h0F, 8'h0F};
    stream(3);
    lit_q = '{8'hAA, 8'h33, 8'hF0, 8'h0F};
    check_got("bp_pt");

    // Short pad; consumed entries must read back as zero.
    do_abort();
    load_key(8'h11, 1'b0);
    load_key(8'h22, 1'b1);
    ct_src_q = '{8'h11, 8'h22};
    stream(0);
    lit_q = '{8'h00, 8'h00};
    check_got("short_pt");
`ifndef OTP_KEY_WRAP_EN
    chk("short_exhausted", {31'b0, exhausted}, 32'd1);
    chk("zeroize_0", {24'b0, u_dut.u_pad.mem_q[0]}, 32'd0);
    chk("zeroize_1", {24'b0, u_dut.u_pad.mem_q[1]}, 32'd0);
`endif

    // Abort with a plaintext word pending, then reload.
    do_abort();
    load_a5_pad();
    pt_ready = 1'b0;
    ct_valid = 1'b1;
    ct_data  = 8'h0F;
    @(negedge clk);
    @(posedge clk); #1;
    ct_valid = 1'b0;
    do_abort();
    @(negedge clk);
    chk("abort_pt_valid", {31'b0, pt_valid}, 32'd0);
    chk("abort_key_ready", {31'b0, key_in_ready}, 32'd1);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    got_q.delete();
    pt_ready = 1'b1;
    load_key(8'h01, 1'b1);
    ct_src_q = '{8'h80};
    stream(0);
    lit_q = '{8'h81};
    check_got("reload_pt");

    // Asynchronous reset in the middle of LOAD.
    do_abort();
    load_key(8'h01, 1'b0);
    load_key(8'h02, 1'b0);
    chk("load_words_left", {29'b0, words_left}, 32'd2);
    #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("arst_words_left", {29'b0, words_left}, 32'd0);
    chk("arst_key_ready", {31'b0, key_in_ready}, 32'd1);
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_pt_valid", {31'b0, pt_valid}, 32'd0);
    chk("arst_exhausted", {31'b0, exhausted}, 32'd0);
    model_clear();
    got_q.delete();
    @(negedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

`ifdef OTP_KEY_WRAP_EN
    // Repeating key: a 2-word pad cycles.
    load_key(8'hA5, 1'b0);
    load_key(8'h3C, 1'b1);
    ct_src_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    stream(0);
    lit_q = '{8'hA5, 8'h3C, 8'hA5, 8'h3C, 8'hA5};
    check_got("wrap_pt");
    chk("wrap_exhausted", {31'b0, exhausted}, 32'd0);
`endif

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/otp_stream_decrypt.md
Name: otp_stream_decrypt

Overview:
Streaming one-time-pad decryptor, the receive-side counterpart of the combinational pad encryptor. It loads a key pad of up to KEY_DEPTH words into an internal buffer. It then XORs each incoming ciphertext word with the next unused pad word and emits plaintext over a valid/ready stream. Each consumed pad word is zeroized, and the block refuses further data once the pad is exhausted.

Parameters:
W, 8, data and key word width in bits
KEY_DEPTH, 16, pad buffer depth in words (power of 2, at least 2)
AW, $clog2(KEY_DEPTH), pointer width (derived; do not override)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
abort  in  1  synchronous pulse; returns the block to IDLE and discards the pad
key_in_valid  in  1  key word valid
key_in_data  in  W  key word
key_in_last  in  1  marks the final pad word
key_in_ready  out  1  key word accepted when valid && ready
ct_valid  in  1  ciphertext valid
ct_data  in  W  ciphertext word
ct_ready  out  1  ciphertext accepted when valid && ready
pt_valid  out  1  plaintext valid
pt_data  out  W  plaintext word
pt_ready  in  1  downstream ready
busy  out  1  state is RUN
exhausted  out  1  state is EXHAUSTED
words_left  out  AW+1  unused pad words remaining

Behaviour:
- Reset values: state = IDLE; all pointers, key_len and the pad buffer cleared to 0; pt_valid = 0; pt_data = 0; exhausted = 0; words_left = 0.
- IDLE:
  - key_in_ready = 1.
  - The first accepted key word is written to pad[0] and the state moves to LOAD.
  - If that word has key_in_last = 1, the state moves directly to RUN with key_len = 1.
- LOAD:
  - key_in_ready = 1 while wr_ptr < KEY_DEPTH.
  - Each accepted word is written to pad[wr_ptr] and wr_ptr increments.
  - On an accepted key_in_last word, or on the word that fills the buffer, key_len = wr_ptr + 1 and the state moves to RUN.
  - ct_ready = 0.
- RUN:
  - key_in_ready = 0.
  - ct_ready = !pt_valid || pt_ready, giving a single output register with no bubble under full throughput.
  - On ct accept: pt_data <= ct_data ^ pad[rd_ptr]; pt_valid <= 1; pad[rd_ptr] <= 0 (zeroize); rd_ptr increments. Latency is 1 cycle.
  - pt_valid stays high with pt_data stable until pt_ready.
  - When the accepted word uses pad[key_len-1], the state moves to EXHAUSTED in the same cycle. That last pt word remains pending and is delivered normally.
- EXHAUSTED:
  - ct_ready = 0 and exhausted = 1.
  - The block leaves this state only via abort or reset.
- words_left = key_len - rd_ptr in RUN/EXHAUSTED, and wr_ptr in LOAD.
- abort, from any state, takes effect on the next edge: state = IDLE, pointers cleared, pad cleared, pt_valid cleared (a pending word is dropped).
- abort has priority over a simultaneous key or ct handshake; that handshake is ignored.
- key_in_valid outside IDLE/LOAD is ignored (ready = 0).
- Reset mid-operation behaves exactly like power-on reset.

Optional Feature:
OTP_KEY_WRAP_EN
- Defined: repeating-key mode.
  - rd_ptr wraps from key_len-1 to 0.
  - Pad words are not zeroized.
  - EXHAUSTED is never entered; exhausted is tied to 0.
  - words_left reports key_len - rd_ptr.
- Undefined: strict one-time behaviour as described above.

Decomposition:
- Package otp_pkg holds:
  - the state enum (IDLE, LOAD, RUN, EXHAUSTED)
  - default W and KEY_DEPTH localparams
- One sub-module, otp_pad_ram: KEY_DEPTH x W register array with one write port, one combinational read port, a per-entry clear, and a global clear. The FSM, pointers and output register stay in the top level.

Test Plan:
- Load pad A5,3C,FF,00 (last on 00) with KEY_DEPTH=4, then send ct 0F,0F,0F,0F with pt_ready = 1 -> pt = AA,33,F0,0F on consecutive cycles; exhausted rises after the 4th accept; a 5th ct_valid sees ct_ready = 0; words_left goes 4,3,2,1,0.
- Backpressure: hold pt_ready = 0 for 3 cycles after the first accept -> pt_valid held, pt_data stable at AA, ct_ready = 0; release -> remaining words follow with no loss or duplication.
- Short pad: load 2 words 11,22 with last on 22, then send ct 11,22 -> pt = 00,00; exhausted set; pad entries read back 0 (zeroized).
- Abort mid-RUN with a pt word pending -> next cycle pt_valid = 0, state IDLE, key_in_ready = 1; reload pad 01 and send ct 80 -> pt = 81.
- Assert rst_n low asynchronously during LOAD -> all outputs return to reset values immediately, without waiting for a clock edge.
- With OTP_KEY_WRAP_EN defined: pad A5,3C (last), send ct 00 five times -> pt = A5,3C,A5,3C,A5; exhausted stays 0.
